// File: rtl/demux_1x2_stream.sv
// Registered 1-to-2 stream demultiplexer with an independent first-word-fall-through
// FIFO per output, so backpressure on one consumer never stalls the other.
module demux_1x2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       s,
  input  logic [WIDTH-1:0]           f,
  input  logic                       f_valid,
  output logic                       f_ready,
  output logic [WIDTH-1:0]           y0,
  output logic                       y0_valid,
  input  logic                       y0_ready,
  output logic [WIDTH-1:0]           y1,
  output logic                       y1_valid,
  input  logic                       y1_ready,
  output logic [$clog2(DEPTH):0]     cnt0,
  output logic [$clog2(DEPTH):0]     cnt1
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]             full;
  logic [1:0]             rdy;
  logic [1:0][CW-1:0]     cnt;
  logic [1:0][WIDTH-1:0]  head;

  assign rdy = {y1_ready, y0_ready};

  // Acceptance looks only at the selected FIFO's occupancy, never at the consumer.
  assign f_ready = en & ~full[s];

  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    occ;
    logic             push;
    logic             pop;

    assign push = f_valid & f_ready & (s == 1'(i));
    assign pop  = (occ != '0) & rdy[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp  <= '0;
        rp  <= '0;
        occ <= '0;
      end else begin
        if (push) wp <= wp + AW'(1);
        if (pop)  rp <= rp + AW'(1);
        case ({push, pop})
          2'b10:   occ <= occ + CW'(1);
          2'b01:   occ <= occ - CW'(1);
          default: occ <= occ;
        endcase
      end
    end

    // Storage carries no reset; the head mux forces zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
      if (push) mem[wp] <= f;
    end

    assign full[i] = (occ == CW'(DEPTH));
    assign cnt[i]  = occ;
    assign head[i] = (occ != '0) ? mem[rp] : '0;
  end

  assign y0       = head[0];
  assign y1       = head[1];
  assign y0_valid = (cnt[0] != '0);
  assign y1_valid = (cnt[1] != '0);
  assign cnt0     = cnt[0];
  assign cnt1     = cnt[1];

endmodule

// File: doc/demux_1x2_stream.md
Name: demux_1x2_stream

Overview:
- Registered, flow-controlled 1-to-2 demultiplexer: routes each accepted input word to output 0 or 1 as selected by `s`.
- Each output has its own FIFO, so a stalled consumer never blocks traffic to the other output.
- Sits directly downstream of the source that produces `f`/`s`/`en`. Replaces the bare combinational demux wherever the consumers apply backpressure.

Parameters:
- WIDTH, 8, data width of input and both outputs.
- DEPTH, 4, entries per output FIFO. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; when 0, no input is accepted
- s  in  1  route select: 0 → output 0, 1 → output 1; sampled with the input word
- f  in  WIDTH  input data word
- f_valid  in  1  input word valid
- f_ready  out  1  input can be accepted this cycle
- y0  out  WIDTH  output 0 data (head of FIFO 0)
- y0_valid  out  1  output 0 holds data
- y0_ready  in  1  consumer 0 takes data
- y1  out  WIDTH  output 1 data (head of FIFO 1)
- y1_valid  out  1  output 1 holds data
- y1_ready  in  1  consumer 1 takes data
- cnt0  out  $clog2(DEPTH)+1  occupancy of FIFO 0
- cnt1  out  $clog2(DEPTH)+1  occupancy of FIFO 1

Behaviour:
- Reset (rst_n low, asynchronous):
  - all pointers, counts, cnt0/cnt1 → 0
  - y0_valid = y1_valid = 0
  - y0 = y1 = 0
  - takes effect immediately, independent of clk
  - release is sampled on the next rising clk
  - words in flight are discarded
- Acceptance:
  - f_ready = en & ~full[s], combinational from en, s and the current counts. It does not depend on y*_ready: no same-cycle bypass of a full FIFO.
  - push into FIFO[s] when f_valid & f_ready at a rising edge
  - f and s are captured at that edge
- Output, first-word-fall-through:
  - yN_valid = (cntN != 0)
  - yN = FIFO[N] head entry; 0 when empty
  - pop when yN_valid & yN_ready
- Latency:
  - a word accepted at edge k is visible on yN with yN_valid = 1 after edge k (one cycle)
  - throughput is one word per cycle per output
- Simultaneous push and pop on the same FIFO:
  - cnt unchanged
  - both pointers advance
  - order preserved
  - push into an empty FIFO with yN_ready high pops only on a later edge (no same-edge pass-through)
- Simultaneous push to one FIFO and pop from the other: independent.
- Full FIFO (cnt == DEPTH):
  - f_ready = 0 only while s selects it
  - changing s to a non-full FIFO raises f_ready in the same cycle
- Empty FIFO: yN_ready is ignored; no pointer movement, cnt stays 0.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH; cnt saturates neither way (overflow/underflow impossible by construction).
- en = 0:
  - no pushes
  - outputs keep draining normally
  - contents retained
- Ordering:
  - words to the same output leave in acceptance order
  - no ordering guarantee between outputs
- Input stability: the upstream stage must hold f, s stable while f_valid & ~f_ready. The block does not check this.
- X handling: s is only meaningful when f_valid = 1; f_ready with f_valid = 0 is informational.

Test Plan:
- Reset/idle: assert rst_n = 0 mid-cycle with both FIFOs holding 2 words → cnt0 = cnt1 = 0, y0_valid = y1_valid = 0, y0 = y1 = 0 immediately. After release with en = 1, f_ready = 1.
- Basic routing: en = 1, y*_ready = 1, send 0xA5 with s = 0, then 0x3C with s = 1 → y0 = 0xA5 valid one cycle after its accept edge; y1 = 0x3C valid one cycle after its accept. Nothing appears on the other output.
- Full/backpressure: y0_ready = 0, send 5 words 0x01..0x05 with s = 0, DEPTH = 4 →
  - first 4 accepted, cnt0 = 4, f_ready = 0 for the 5th
  - switch s = 1 → f_ready = 1 and 0x05 goes to output 1
  - release y0_ready → 0x01..0x04 emerge in order
- Concurrent push/pop: FIFO 0 holds 2, y0_ready = 1, continuous s = 0 stream 0x10, 0x11, ... for 8 cycles → cnt0 stays 2 throughout; output order exact, including across pointer wrap.
- Enable gating: en = 0 with f_valid = 1 for 3 cycles while FIFO 1 holds 3 words and y1_ready = 1 → f_ready = 0, nothing accepted, cnt1 drains 3 → 0. en = 1 → accept resumes next edge.
- Empty pop: y0_ready = 1, FIFO 0 empty, no input for 4 cycles → y0_valid = 0, y0 = 0, cnt0 = 0 throughout.
